// File: rtl/s1c88_bus_ctrl.sv
// s1c88_bus_ctrl: byte-serial read/write burst and exception-vector fetch sequencer for the S1C88 core.
// Build option S1C88_BUS_WAIT_EN adds a bus_wait input that stretches T2 of any bus cycle.
//
// state   | meaning
// RST_DLY | RESET_DELAY idle bus cycles after reset, address all-ones
// IDLE    | phase counter parked; arbitrate exceptions, else accept a request
// XFER    | read/write burst, one four-phase bus cycle per byte
// VEC     | two-byte vector fetch (low byte, then high byte)
module s1c88_bus_ctrl #(
  parameter int ADDR_WIDTH  = 24,
  parameter int MAX_BURST   = 4,
  parameter int VECTOR_BASE = 0,
  parameter int RESET_DELAY = 2,
  localparam int LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_sync,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [8*MAX_BURST-1:0]  req_wdata,
  output logic                    rsp_valid,
  output logic [8*MAX_BURST-1:0]  rsp_rdata,
  input  logic [4:0]              exc_req,
  output logic                    exc_ack,
  output logic [2:0]              exc_type,
  output logic [15:0]             vec_pc,
`ifdef S1C88_BUS_WAIT_EN
  input  logic                    bus_wait,
`endif
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic [ADDR_WIDTH-1:0]   address_out,
  output logic [1:0]              bus_status,
  output logic                    read,
  output logic                    write,
  output logic                    sync,
  output logic                    iack,
  output logic                    pk,
  output logic                    pl
);

  typedef enum logic [1:0] {RST_DLY, IDLE, XFER, VEC} state_t;

  localparam logic [1:0] BS_IDLE = 2'd0;
  localparam logic [1:0] BS_IRQ  = 2'd1;
  localparam logic [1:0] BS_WR   = 2'd2;
  localparam logic [1:0] BS_RD   = 2'd3;
  localparam int DLY_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY + 1) : 1;

  state_t                   state, state_nxt;
  logic [1:0]               ph;
  logic [DLY_W-1:0]         dly_cnt;
  logic [LEN_W-1:0]         byte_idx, idx_nxt, len_q;
  logic                     wr_q;
  logic [8*MAX_BURST-1:0]   wbuf;
  logic [7:0]               wbyte_nxt;
  logic [1:0]               holdoff;
  logic [2:0]               vec_type;
  logic                     accept, vec_start;
  logic                     stall, mid, dly_done, exc_live;

  function automatic logic [ADDR_WIDTH-1:0] vec_addr(input logic [2:0] t);
    return ADDR_WIDTH'(VECTOR_BASE) + ADDR_WIDTH'({t, 1'b0});
  endfunction

`ifdef S1C88_BUS_WAIT_EN
  assign stall = bus_wait && (ph == 2'd2) && ((state == XFER) || (state == VEC));
`else
  assign stall = 1'b0;
`endif

  assign mid      = (ph == 2'd1) || (ph == 2'd2);
  assign dly_done = (dly_cnt <= DLY_W'(1));
  // After an ack the source gets two clocks to drop its level before it can win again.
  assign exc_live = (exc_req != 5'd0) && (holdoff == 2'd0);
  assign idx_nxt  = byte_idx + LEN_W'(1);
  assign pk       = ph[0];
  assign pl       = ph[1];

  always_comb begin
    vec_type = 3'd5;
    if (exc_req[4])      vec_type = 3'd1;
    else if (exc_req[3]) vec_type = 3'd2;
    else if (exc_req[2]) vec_type = 3'd3;
    else if (exc_req[1]) vec_type = 3'd4;
  end

  always_comb begin
    wbyte_nxt = 8'hFF;
    for (int b = 0; b < MAX_BURST; b++) begin
      if (LEN_W'(b) == idx_nxt) wbyte_nxt = wbuf[8*b +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    vec_start = 1'b0;
    req_ready = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    iack      = 1'b0;
    case (state)
      RST_DLY: begin
        if ((ph == 2'd3) && dly_done) state_nxt = VEC;
      end
      IDLE: begin
        req_ready = (exc_req == 5'd0);
        if (exc_live) begin
          vec_start = 1'b1;
          state_nxt = VEC;
        end else if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        read  = mid && !wr_q;
        write = mid && wr_q;
        if ((ph == 2'd3) && (byte_idx == len_q)) state_nxt = IDLE;
      end
      VEC: begin
        read = mid;
        iack = (exc_type != 3'd0);
        if ((ph == 2'd3) && (byte_idx != '0)) state_nxt = IDLE;
      end
      default: state_nxt = RST_DLY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RST_DLY;
      ph          <= 2'd0;
      dly_cnt     <= DLY_W'(RESET_DELAY);
      byte_idx    <= '0;
      len_q       <= '0;
      wr_q        <= 1'b0;
      wbuf        <= '0;
      holdoff     <= 2'd0;
      address_out <= '1;
      data_out    <= 8'hFF;
      bus_status  <= BS_IDLE;
      sync        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      exc_ack     <= 1'b0;
      exc_type    <= 3'd0;
      vec_pc      <= 16'h0000;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 1'b0;
      exc_ack   <= 1'b0;
      if (holdoff != 2'd0) holdoff <= holdoff - 2'd1;
      if ((state != IDLE) && !stall) ph <= ph + 2'd1;

      case (state)
        RST_DLY: begin
          if (ph == 2'd3) begin
            if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
            if (dly_done) begin
              exc_type    <= 3'd0;
              byte_idx    <= '0;
              address_out <= vec_addr(3'd0);
              bus_status  <= BS_RD;
            end
          end
        end
        IDLE: begin
          if (vec_start) begin
            exc_type    <= vec_type;
            byte_idx    <= '0;
            address_out <= vec_addr(vec_type);
            bus_status  <= BS_IRQ;
            sync        <= 1'b0;
            data_out    <= 8'hFF;
          end else if (accept) begin
            len_q       <= req_len;
            wr_q        <= req_write;
            wbuf        <= req_wdata;
            byte_idx    <= '0;
            address_out <= req_addr;
            bus_status  <= req_write ? BS_WR : BS_RD;
            sync        <= req_sync;
            data_out    <= req_write ? req_wdata[7:0] : 8'hFF;
            rsp_rdata   <= '0;
          end
        end
        XFER: begin
          if ((ph == 2'd2) && !stall && !wr_q) begin
            for (int b = 0; b < MAX_BURST; b++) begin
              if (LEN_W'(b) == byte_idx) rsp_rdata[8*b +: 8] <= data_in;
            end
          end
          if (ph == 2'd3) begin
            sync <= 1'b0;
            if (byte_idx == len_q) begin
              rsp_valid  <= 1'b1;
              bus_status <= BS_IDLE;
            end else begin
              byte_idx    <= idx_nxt;
              address_out <= address_out + 1'b1;
              if (wr_q) data_out <= wbyte_nxt;
            end
          end
        end
        VEC: begin
          if ((ph == 2'd2) && !stall) begin
            if (byte_idx == '0) vec_pc[7:0]  <= data_in;
            else                vec_pc[15:8] <= data_in;
          end
          if (ph == 2'd3) begin
            if (byte_idx == '0) begin
              byte_idx    <= LEN_W'(1);
              address_out <= address_out + 1'b1;
            end else begin
              exc_ack    <= 1'b1;
              holdoff    <= 2'd2;
              bus_status <= BS_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
